// File: rtl/fpnew_pkg.sv
// rtl/fpnew_pkg.sv - FPnew shared enums/status used by the slice arbiter
package fpnew_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011,
    RMM = 3'b100, ROD = 3'b101, DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  // Index width that stays legal for a single-entry range.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpnew_arb_id_fifo.sv
// rtl/fpnew_arb_id_fifo.sv - in-order requester-ID queue for the slice arbiter
module fpnew_arb_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned DataW = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DataW-1:0]           data_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic [DataW-1:0]           head_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [DataW-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push_i) r_wptr <= ptr_inc(r_wptr);
      if (pop_i)  r_rptr <= ptr_inc(r_rptr);
      if (push_i && !pop_i)      r_count <= r_count + 1'b1;
      else if (pop_i && !push_i) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset; a full-queue push lands in the slot being popped.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && push_i) r_mem[r_wptr] <= data_i;
  end

  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rptr];

endmodule

// File: rtl/fpnew_slice_arbiter.sv
// rtl/fpnew_slice_arbiter.sv - shares one format slice between NumReq requesters
// FPNEW_SLICE_ARB_RR_EN selects round-robin; otherwise fixed priority (lowest index).
module fpnew_slice_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned Width       = 32,
  parameter int unsigned NumOperands = 3,
  parameter int unsigned MaxInFlight = 4,
  parameter type         TagType     = logic
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic [NumReq-1:0][NumOperands-1:0][Width-1:0]   req_operands_i,
  input  roundmode_e [NumReq-1:0]                         req_rnd_mode_i,
  input  operation_e [NumReq-1:0]                         req_op_i,
  input  logic [NumReq-1:0]                               req_op_mod_i,
  input  logic [NumReq-1:0]                               req_vectorial_i,
  input  TagType [NumReq-1:0]                             req_tag_i,
  input  logic [NumReq-1:0]                               req_valid_i,
  output logic [NumReq-1:0]                               req_ready_o,
  output logic [Width-1:0]                                rsp_result_o,
  output status_t                                         rsp_status_o,
  output TagType                                          rsp_tag_o,
  output logic [NumReq-1:0]                               rsp_valid_o,
  input  logic [NumReq-1:0]                               rsp_ready_i,
  output logic [NumOperands-1:0][Width-1:0]               slc_operands_o,
  output roundmode_e                                      slc_rnd_mode_o,
  output operation_e                                      slc_op_o,
  output logic                                            slc_op_mod_o,
  output logic                                            slc_vectorial_o,
  output TagType                                          slc_tag_o,
  output logic                                            slc_in_valid_o,
  input  logic                                            slc_in_ready_i,
  input  logic [Width-1:0]                                slc_result_i,
  input  status_t                                         slc_status_i,
  input  TagType                                          slc_tag_i,
  input  logic                                            slc_out_valid_i,
  output logic                                            slc_out_ready_o,
  input  logic                                            flush_i,
  output logic                                            slc_flush_o,
  output logic                                            busy_o
);
  localparam int unsigned IdW  = idx_width(NumReq);
  localparam int unsigned CntW = $clog2(MaxInFlight + 1);

  typedef logic [IdW-1:0] id_t;
  typedef struct packed {
    logic [NumOperands-1:0][Width-1:0] operands;
    roundmode_e                        rnd_mode;
    operation_e                        op;
    logic                              op_mod;
    logic                              vectorial;
    TagType                            tag;
  } arb_req_t;

  logic            w_issue_ok, w_rsp_ok, w_push, w_pop, w_full, w_empty;
  logic [CntW-1:0] w_count;
  id_t             w_head, w_pick, w_winner;
  arb_req_t        w_req;
  logic            r_locked;
  id_t             r_lock_idx;

`ifdef FPNEW_SLICE_ARB_RR_EN
  id_t r_rr_ptr;

  always_comb begin
    id_t  idx;
    logic found;
    idx    = r_rr_ptr;
    found  = 1'b0;
    w_pick = r_rr_ptr;
    for (int k = 0; k < NumReq; k++) begin
      if (!found && req_valid_i[idx]) begin
        w_pick = idx;
        found  = 1'b1;
      end
      idx = (idx == id_t'(NumReq - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Pointer survives a flush so fairness carries across it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)     r_rr_ptr <= '0;
    else if (w_push) r_rr_ptr <= (w_winner == id_t'(NumReq - 1)) ? '0 : w_winner + 1'b1;
  end
`else
  always_comb begin
    w_pick = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_valid_i[i]) w_pick = id_t'(i);
    end
  end
`endif

  assign w_winner       = r_locked ? r_lock_idx : w_pick;
  assign w_issue_ok     = rst_ni & ~flush_i & ~w_full;
  assign slc_in_valid_o = (|req_valid_i) & w_issue_ok;
  assign w_push         = slc_in_valid_o & slc_in_ready_i;

  always_comb begin
    req_ready_o           = '0;
    req_ready_o[w_winner] = w_issue_ok & slc_in_ready_i;
  end

  // A stalled offer is pinned so the slice never sees its input change mid-handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_push) begin
      r_locked   <= 1'b0;
    end else if (slc_in_valid_o) begin
      r_locked   <= 1'b1;
      r_lock_idx <= w_winner;
    end
  end

  always_comb begin
    w_req.operands  = req_operands_i[w_winner];
    w_req.rnd_mode  = req_rnd_mode_i[w_winner];
    w_req.op        = req_op_i[w_winner];
    w_req.op_mod    = req_op_mod_i[w_winner];
    w_req.vectorial = req_vectorial_i[w_winner];
    w_req.tag       = req_tag_i[w_winner];
  end

  assign slc_operands_o  = w_req.operands;
  assign slc_rnd_mode_o  = w_req.rnd_mode;
  assign slc_op_o        = w_req.op;
  assign slc_op_mod_o    = w_req.op_mod;
  assign slc_vectorial_o = w_req.vectorial;
  assign slc_tag_o       = w_req.tag;

  fpnew_arb_id_fifo #(
    .Depth (MaxInFlight),
    .DataW (IdW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_winner),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count),
    .head_o  (w_head)
  );

  assign w_rsp_ok        = rst_ni & ~flush_i & ~w_empty;
  assign slc_out_ready_o = rsp_ready_i[w_head] & w_rsp_ok;
  assign w_pop           = slc_out_valid_i & slc_out_ready_o;

  always_comb begin
    rsp_valid_o         = '0;
    rsp_valid_o[w_head] = slc_out_valid_i & w_rsp_ok;
  end

  assign rsp_result_o = slc_result_i;
  assign rsp_status_o = slc_status_i;
  assign rsp_tag_o    = slc_tag_i;
  assign slc_flush_o  = flush_i;
  assign busy_o       = rst_ni & ((w_count != '0) | slc_in_valid_o);

  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      assert (!(slc_out_valid_i && w_empty))
        else $error("slice result arrived with an empty ID queue");
    end
  end

endmodule

// File: tb/tb_fpnew_slice_arbiter.sv
// tb/tb_fpnew_slice_arbiter.sv - directed bench; u_dut uses 4-deep queue, u_dut2 2-deep
module tb_fpnew_slice_arbiter;
  import fpnew_pkg::*;

`ifdef FPNEW_SLICE_ARB_RR_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0][2:0][31:0] opnd;
  roundmode_e [3:0]      rnd;
  operation_e [3:0]      op;
  logic [3:0]            op_mod, vec, tag, valid, rsp_ready;
  logic                  in_ready, out_valid, flush;
  logic [31:0]           slc_result;
  status_t               slc_status;
  logic                  slc_tag_in;

  logic [3:0]       req_ready, rsp_valid, req_ready_2, rsp_valid_2;
  logic [31:0]      rsp_result, rsp_result_2;
  status_t          rsp_status, rsp_status_2;
  logic             rsp_tag, rsp_tag_2;
  logic [2:0][31:0] slc_opnd, slc_opnd_2;
  roundmode_e       slc_rnd, slc_rnd_2;
  operation_e       slc_op, slc_op_2;
  logic             slc_op_mod, slc_vec, slc_tag, in_valid, out_ready, slc_flush, busy;
  logic             slc_op_mod_2, slc_vec_2, slc_tag_2, in_valid_2, out_ready_2, slc_flush_2, busy_2;

  fpnew_slice_arbiter #(.NumReq(4), .Width(32), .NumOperands(3), .MaxInFlight(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_operands_i(opnd), .req_rnd_mode_i(rnd), .req_op_i(op), .req_op_mod_i(op_mod),
    .req_vectorial_i(vec), .req_tag_i(tag), .req_valid_i(valid), .req_ready_o(req_ready),
    .rsp_result_o(rsp_result), .rsp_status_o(rsp_status), .rsp_tag_o(rsp_tag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .slc_operands_o(slc_opnd), .slc_rnd_mode_o(slc_rnd), .slc_op_o(slc_op),
    .slc_op_mod_o(slc_op_mod), .slc_vectorial_o(slc_vec), .slc_tag_o(slc_tag),
    .slc_in_valid_o(in_valid), .slc_in_ready_i(in_ready),
    .slc_result_i(slc_result), .slc_status_i(slc_status), .slc_tag_i(slc_tag_in),
    .slc_out_valid_i(out_valid), .slc_out_ready_o(out_ready),
    .flush_i(flush), .slc_flush_o(slc_flush), .busy_o(busy)
  );

  fpnew_slice_arbiter #(.NumReq(4), .Width(32), .NumOperands(3), .MaxInFlight(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_operands_i(opnd), .req_rnd_mode_i(rnd), .req_op_i(op), .req_op_mod_i(op_mod),
    .req_vectorial_i(vec), .req_tag_i(tag), .req_valid_i(valid), .req_ready_o(req_ready_2),
    .rsp_result_o(rsp_result_2), .rsp_status_o(rsp_status_2), .rsp_tag_o(rsp_tag_2),
    .rsp_valid_o(rsp_valid_2), .rsp_ready_i(rsp_ready),
    .slc_operands_o(slc_opnd_2), .slc_rnd_mode_o(slc_rnd_2), .slc_op_o(slc_op_2),
    .slc_op_mod_o(slc_op_mod_2), .slc_vectorial_o(slc_vec_2), .slc_tag_o(slc_tag_2),
    .slc_in_valid_o(in_valid_2), .slc_in_ready_i(in_ready),
    .slc_result_i(slc_result), .slc_status_i(slc_status), .slc_tag_i(slc_tag_in),
    .slc_out_valid_i(out_valid), .slc_out_ready_o(out_ready_2),
    .flush_i(flush), .slc_flush_o(slc_flush_2), .busy_o(busy_2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_g, prev_g;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] opv(input int i, input int j);
    return 32'hC0DE_0000 | 32'(i << 8) | 32'(j);
  endfunction

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) opnd[i][j] = opv(i, j);
      rnd[i]    = roundmode_e'(i);
      op[i]     = operation_e'(i + 2);
      op_mod[i] = i[0];
      vec[i]    = 1'b0;
      tag[i]    = i[1];
    end
    slc_result = 32'h0;
    slc_status = '0;
    slc_tag_in = 1'b0;

    // reset: outputs quiet even with traffic offered
    rst_n = 1'b0; flush = 1'b1; valid = 4'hF; in_ready = 1'b1;
    out_valid = 1'b1; rsp_ready = 4'hF;
    cyc(); cyc();
    check("rst_req_ready", req_ready, 4'h0);
    check("rst_in_valid", in_valid, 1'b0);
    check("rst_rsp_valid", rsp_valid, 4'h0);
    check("rst_out_ready", out_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_flush_hi", slc_flush, 1'b1);
    flush = 1'b0; #1;
    check("rst_flush_lo", slc_flush, 1'b0);
    out_valid = 1'b0; valid = 4'h0; rst_n = 1'b1;
    cyc();

    // all requesters valid, one pop per cycle after the first issue
    valid = 4'hF; in_ready = 1'b1; rsp_ready = 4'hF; prev_g = 0;
    for (int k = 0; k < 5; k++) begin
      out_valid = (k > 0);
      #1;
      exp_g = RR ? (k % 4) : 0;
      check("arb_ready", req_ready, oh(exp_g));
      check("arb_opnd", slc_opnd[2], opv(exp_g, 2));
      if (k > 0) check("arb_rsp", rsp_valid, oh(prev_g));
      prev_g = exp_g;
      cyc();
    end
    valid = 4'h0; out_valid = 1'b1; #1;
    check("arb_drain_rsp", rsp_valid, oh(prev_g));
    check("arb_drain_ordy", out_ready, 1'b1);
    cyc();
    out_valid = 1'b0; #1;
    check("arb_idle_busy", busy, 1'b0);

    // grant lock: requester 2 stalled, requester 0 joins in the second cycle
    valid = 4'b0100; in_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) valid = 4'b0101;
      #1;
      check("lock_in_valid", in_valid, 1'b1);
      check("lock_opnd", slc_opnd[0], opv(2, 0));
      check("lock_ready", req_ready, 4'h0);
      cyc();
    end
    in_ready = 1'b1; #1;
    check("lock_accept2", req_ready, 4'b0100);
    check("lock_rnd2", slc_rnd, roundmode_e'(2));
    cyc();
    valid = 4'b0001; #1;
    check("lock_accept0", req_ready, 4'b0001);
    check("lock_opnd0", slc_opnd[1], opv(0, 1));
    cyc();
    valid = 4'h0; out_valid = 1'b1; #1;
    check("lock_rsp2", rsp_valid, 4'b0100);
    cyc();
    check("lock_rsp0", rsp_valid, 4'b0001);
    cyc();
    out_valid = 1'b0;

    // response backpressure on head requester 1
    valid = 4'b0010; #1;
    check("bp_issue", req_ready, 4'b0010);
    cyc();
    valid = 4'h0; out_valid = 1'b1; rsp_ready = 4'b1000; slc_result = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_out_ready", out_ready, 1'b0);
      check("bp_rsp_valid", rsp_valid, 4'b0010);
      cyc();
    end
    rsp_ready = 4'b0010; #1;
    check("bp_release", out_ready, 1'b1);
    check("bp_result", rsp_result, 32'hDEAD_BEEF);
    cyc();
    out_valid = 1'b0; rsp_ready = 4'hF; #1;
    check("bp_busy", busy, 1'b0);

    // full queue on the 2-deep instance
    valid = 4'b1000; in_ready = 1'b1; out_valid = 1'b0;
    #1; check("full_f1", in_valid_2, 1'b1); cyc();
    check("full_f2", in_valid_2, 1'b1); cyc();
    check("full_f3_inv", in_valid_2, 1'b0);
    check("full_f3_rdy", req_ready_2, 4'h0);
    check("full_f3_big", in_valid, 1'b1);
    cyc();
    out_valid = 1'b1; #1;
    check("full_f4_inv", in_valid_2, 1'b0);
    check("full_f4_ordy", out_ready_2, 1'b1);
    check("full_f4_rsp", rsp_valid_2, 4'b1000);
    cyc();
    check("full_f5_inv", in_valid_2, 1'b1);
    check("full_f5_ordy", out_ready_2, 1'b1);
    cyc();
    out_valid = 1'b0; #1;
    check("full_f6_inv", in_valid_2, 1'b1);
    cyc();
    check("full_f7_inv", in_valid_2, 1'b0);
    check("full_f7_busy", busy_2, 1'b1);
    valid = 4'h0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;

    // flush with three in flight
    valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("fl_issue", req_ready, oh(RR ? k : 0));
      cyc();
    end
    flush = 1'b1; out_valid = 1'b1; #1;
    check("fl_slc_flush", slc_flush, 1'b1);
    check("fl_in_valid", in_valid, 1'b0);
    check("fl_rsp_valid", rsp_valid, 4'h0);
    check("fl_out_ready", out_ready, 1'b0);
    check("fl_req_ready", req_ready, 4'h0);
    cyc();
    flush = 1'b0; valid = 4'h0; out_valid = 1'b0; #1;
    check("fl_busy", busy, 1'b0);
    check("fl_busy2", busy_2, 1'b0);
    valid = 4'hF; #1;
    prev_g = RR ? 3 : 0;
    check("fl_next_grant", req_ready, oh(prev_g));
    cyc();

    // requesters 1 and 3 continuously valid
    valid = 4'b1010; out_valid = 1'b1; rsp_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_g = (RR != 0 && k % 2 == 1) ? 3 : 1;
      check("prio_grant", req_ready, oh(exp_g));
      check("prio_rsp", rsp_valid, oh(prev_g));
      prev_g = exp_g;
      cyc();
    end
    valid = 4'h0; #1;
    check("prio_drain", rsp_valid, oh(prev_g));
    cyc();
    out_valid = 1'b0; #1;
    check("prio_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
